// File: rtl/eth_tx_ring_node.sv
// eth_tx_ring_node
//   Client station on the 1000BASE-T DMA TX token ring. A local producer
//   writes one packet into a single-packet buffer. When the free token
//   (tx_start_empty) passes, the node consumes it and emits a tx_start
//   header, then the packet (tx_data ... tx_end). Otherwise, ring traffic
//   is forwarded through one register stage.
//
// Build option:
//   ETH_TX_NODE_PAD_EN - pads committed packets shorter than 15 words
//                        (60 bytes) with zero words up to 15 words.
//
// Parameters:
//   DEPTH - buffer depth in 32-bit words, power of two, at least 2
//   PID   - value placed in msg.header.pid of the emitted tx_start word
//
// Ports:
//   clk         ring clock
//   reset       synchronous, active-high reset
//   tx_ring_in  ring from the previous station
//   tx_ring_out ring to the next station / ring master (registered)
//   wr_en       write one word into the buffer
//   wr_data     packet word
//   wr_last     with wr_en: final word, commits the packet
//   wr_ready    buffer accepts writes (registered, high in FILL)
//   tx_done     one-cycle pulse in the cycle after tx_end is driven
//   overflow    sticky: words beyond DEPTH were dropped
//   ring_err    sticky: non-tx_none input arrived while transmitting

package eth_tx_ring_pkg;

    typedef enum logic [2:0] {
        tx_none        = 3'd0,
        tx_start_empty = 3'd1,
        tx_start       = 3'd2,
        slot_start     = 3'd3,
        tx_data        = 3'd4,
        tx_end         = 3'd5
    } eth_tx_ring_stype_t;

    typedef struct packed {
        logic [15:0] rsvd;
        logic [7:0]  flags;
        logic [7:0]  pid;
    } eth_tx_ring_header_t;

    typedef union packed {
        logic [31:0]         data;
        eth_tx_ring_header_t header;
    } eth_tx_ring_msg_t;

    typedef struct packed {
        eth_tx_ring_stype_t stype;
        eth_tx_ring_msg_t   msg;
    } eth_tx_ring_data_type;

endpackage

module eth_tx_ring_node
    import eth_tx_ring_pkg::*;
#(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned PID   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  eth_tx_ring_data_type tx_ring_in,
    output eth_tx_ring_data_type tx_ring_out,
    input  logic                 wr_en,
    input  logic [31:0]          wr_data,
    input  logic                 wr_last,
    output logic                 wr_ready,
    output logic                 tx_done,
    output logic                 overflow,
    output logic                 ring_err
);

    localparam int unsigned AW  = $clog2(DEPTH);
    // Counters must also hold the padded length of 15 words.
    localparam int unsigned CAP = (DEPTH > 15) ? DEPTH : 15;
    localparam int unsigned CW  = $clog2(CAP + 1);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    typedef enum logic [1:0] {
        FILL,
        READY,
        SEND,
        TAIL
    } state_t;

    state_t        state;
    logic [31:0]   mem [DEPTH];
    logic [31:0]   rd_q;
    logic [AW-1:0] rd_addr;
    logic [CW-1:0] cnt;
    logic [CW-1:0] wlen;
    logic [CW-1:0] len;
    logic [CW-1:0] idx;
    logic [CW-1:0] commit_wlen;
    logic [CW-1:0] commit_len;
    logic          mem_we;

    assign mem_we = (state == FILL) && wr_ready && wr_en && (cnt < DEPTH_C);

    // In SEND, rd_q holds word idx while word idx+1 is fetched, so words go
    // out back to back; outside SEND, word 0 is kept prefetched.
    always_comb begin
        rd_addr = '0;
        if (state == SEND) begin
            rd_addr = AW'(idx + ONE_C);
        end
    end

    always_comb begin
        commit_wlen = (cnt < DEPTH_C) ? cnt + ONE_C : DEPTH_C;
        commit_len  = commit_wlen;
`ifdef ETH_TX_NODE_PAD_EN
        if (commit_wlen < CW'(15)) begin
            commit_len = CW'(15);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[cnt[AW-1:0]] <= wr_data;
        end
        rd_q <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= FILL;
            cnt               <= '0;
            wlen              <= '0;
            len               <= '0;
            idx               <= '0;
            tx_ring_out.stype <= tx_none;
            tx_ring_out.msg   <= '0;
            wr_ready          <= 1'b0;
            tx_done           <= 1'b0;
            overflow          <= 1'b0;
            ring_err          <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            unique case (state)
                FILL: begin
                    tx_ring_out <= tx_ring_in;
                    wr_ready    <= 1'b1;
                    if (wr_ready && wr_en) begin
                        if (cnt < DEPTH_C) begin
                            cnt <= cnt + ONE_C;
                        end else begin
                            overflow <= 1'b1;
                        end
                        if (wr_last) begin
                            wlen     <= commit_wlen;
                            len      <= commit_len;
                            wr_ready <= 1'b0;
                            state    <= READY;
                        end
                    end
                end
                READY: begin
                    if (tx_ring_in.stype == tx_start_empty) begin
                        tx_ring_out.stype          <= tx_start;
                        tx_ring_out.msg            <= '0;
                        tx_ring_out.msg.header.pid <= 8'(PID);
                        idx                        <= '0;
                        state                      <= SEND;
                    end else begin
                        tx_ring_out <= tx_ring_in;
                    end
                end
                SEND: begin
                    if (tx_ring_in.stype != tx_none) begin
                        ring_err <= 1'b1;
                    end
                    // Words past the written length are pad words.
                    tx_ring_out.msg.data <= (idx < wlen) ? rd_q : '0;
                    if (idx == len - ONE_C) begin
                        tx_ring_out.stype <= tx_end;
                        state             <= TAIL;
                    end else begin
                        tx_ring_out.stype <= tx_data;
                        idx               <= idx + ONE_C;
                    end
                end
                TAIL: begin
                    if (tx_ring_in.stype != tx_none) begin
                        ring_err <= 1'b1;
                    end
                    tx_ring_out.stype <= tx_none;
                    tx_ring_out.msg   <= '0;
                    tx_done           <= 1'b1;
                    cnt               <= '0;
                    wr_ready          <= 1'b1;
                    state             <= FILL;
                end
            endcase
        end
    end

endmodule
